// File: rtl/shift_pipe_pkg.sv
// shift_pipe_pkg: opcodes, level-to-stage mapping and op decode shared by shift_pipe.
// Rotate decode depends on SHIFT_PIPE_ROTATE_EN.
package shift_pipe_pkg;
  localparam int SHIFT_OP_W = 3;
  localparam logic [SHIFT_OP_W-1:0] SHIFT_OP_SLL = 3'd0, SHIFT_OP_SRL = 3'd1, SHIFT_OP_SRA = 3'd2,
                                    SHIFT_OP_ROL = 3'd3, SHIFT_OP_ROR = 3'd4;
  function automatic int stage_last_level(int l, int p, int s);
    return (l * (s + 1) + p - 1) / p - 1;
  endfunction
  // inverse of stage_last_level: the stage whose register follows level k
  function automatic int level_stage(int l, int p, int k);
    return k * p / l;
  endfunction
  function automatic logic op_err(logic [SHIFT_OP_W-1:0] op);
`ifdef SHIFT_PIPE_ROTATE_EN
    return op > SHIFT_OP_ROR;
`else
    return op > SHIFT_OP_SRA;
`endif
  endfunction
  function automatic logic op_rot(logic [SHIFT_OP_W-1:0] op);
`ifdef SHIFT_PIPE_ROTATE_EN
    return op == SHIFT_OP_ROL || op == SHIFT_OP_ROR;
`else
    return 1'b0;
`endif
  endfunction
  function automatic logic op_rev(logic [SHIFT_OP_W-1:0] op);
    return op == SHIFT_OP_SRL || op == SHIFT_OP_SRA || (op_rot(op) && op == SHIFT_OP_ROR);
  endfunction
endpackage

// File: rtl/shift_level.sv
// shift_level: one barrel level, moves the word left by SH when its amount bit is set.
module shift_level #(
  parameter int WIDTH = 32,
  parameter int SH = 1
) (
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_amt_bit,
  input  logic             i_fill,
  input  logic             i_rot,
  output logic [WIDTH-1:0] o_word
);
  logic [SH-1:0] w_in;
  assign w_in = i_rot ? i_word[WIDTH-1 -: SH] : {SH{i_fill}};
  assign o_word = i_amt_bit ? {i_word[WIDTH-SH-1:0], w_in} : i_word;
endmodule

// File: rtl/shift_pipe.sv
// shift_pipe: pipelined barrel shifter/rotator with valid/ready handshakes and a carried tag.
// Rotates are built only when SHIFT_PIPE_ROTATE_EN is defined; otherwise 011/100 are illegal.
module shift_pipe import shift_pipe_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_amt,
  input  logic [SHIFT_OP_W-1:0]    in_op,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_err
);
  localparam int L = $clog2(WIDTH);
  localparam int P = PIPE_STAGES;
  logic [P-1:0] r_valid, r_fill, r_err, w_adv, w_take, w_s_fill, w_s_err;
  logic [P-1:0][WIDTH-1:0] r_word, w_s_word, w_nxt;
  logic [P-1:0][L-1:0] r_amt, w_s_amt;
  logic [P-1:0][SHIFT_OP_W-1:0] r_op, w_s_op;
  logic [P-1:0][TAG_W-1:0] r_tag, w_s_tag;
  logic [L-1:0][WIDTH-1:0] w_lv;
  logic w_in_err, w_unused;
  function automatic logic [WIDTH-1:0] bit_rev(logic [WIDTH-1:0] w);
    for (int i = 0; i < WIDTH; i++) bit_rev[i] = w[WIDTH-1-i];
  endfunction
  assign w_in_err = op_err(in_op);
  assign in_ready = rst_n && (!r_valid[0] || w_adv[0]);
  assign out_valid = r_valid[P-1];
  assign out_data = r_word[P-1];
  assign out_tag = r_tag[P-1];
  assign out_err = r_err[P-1];
  assign w_unused = ^{r_amt, w_s_amt, r_op, r_fill};
  for (genvar s = 0; s < P; s++) begin : g_st
    localparam int E = stage_last_level(L, P, s);
    if (s == 0) begin : g_src
      // illegal ops travel with amount 0 and no reversal, so the data passes through
      assign w_s_word[s] = op_rev(in_op) ? bit_rev(in_data) : in_data;
      assign w_s_amt[s] = w_in_err ? '0 : in_amt;
      assign w_s_op[s] = in_op;
      assign w_s_fill[s] = in_op == SHIFT_OP_SRA && in_data[WIDTH-1];
      assign w_s_tag[s] = in_tag;
      assign w_s_err[s] = w_in_err;
      assign w_take[s] = in_valid && in_ready;
    end else begin : g_src
      assign w_s_word[s] = r_word[s-1];
      assign w_s_amt[s] = r_amt[s-1];
      assign w_s_op[s] = r_op[s-1];
      assign w_s_fill[s] = r_fill[s-1];
      assign w_s_tag[s] = r_tag[s-1];
      assign w_s_err[s] = r_err[s-1];
      assign w_take[s] = w_adv[s-1];
    end
    if (s == P - 1) begin : g_end
      assign w_nxt[s] = op_rev(w_s_op[s]) ? bit_rev(w_lv[E]) : w_lv[E];
      assign w_adv[s] = r_valid[s] && out_ready;
    end else begin : g_end
      assign w_nxt[s] = w_lv[E];
      // a stage moves if any later stage has a hole or the output drains
      assign w_adv[s] = r_valid[s] && (out_ready || !(&r_valid[P-1:s+1]));
    end
  end
  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int S = level_stage(L, P, k);
    logic [WIDTH-1:0] w_in;
    if (k == 0 || level_stage(L, P, k - 1) != S) begin : g_in
      assign w_in = w_s_word[S];
    end else begin : g_in
      assign w_in = w_lv[k-1];
    end
    shift_level #(.WIDTH(WIDTH), .SH(1 << k)) u_lvl (
      .i_word(w_in),
      .i_amt_bit(w_s_amt[S][k]),
      .i_fill(w_s_fill[S]),
      .i_rot(op_rot(w_s_op[S])),
      .o_word(w_lv[k])
    );
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_valid <= '0;
      r_word <= '0;
      r_amt <= '0;
      r_op <= '0;
      r_fill <= '0;
      r_tag <= '0;
      r_err <= '0;
    end else begin
      r_valid <= w_take | (r_valid & ~w_adv);
      for (int s = 0; s < P; s++)
        if (w_take[s]) begin
          r_word[s] <= w_nxt[s];
          r_amt[s] <= w_s_amt[s];
          r_op[s] <= w_s_op[s];
          r_fill[s] <= w_s_fill[s];
          r_tag[s] <= w_s_tag[s];
          r_err[s] <= w_s_err[s];
        end
    end
endmodule
